// File: rtl/issue_select_scheduler.sv
// issue_select_scheduler
//   Picks up to two ready issue-queue entries per cycle, scanning round-robin
//   from rr_ptr, and binds each to a distinct available functional unit
//   (0=ALU0, 1=ALU1, 2=MEM). Multi-cycle FU occupancy is tracked with
//   per-FU busy counters. All outputs are registered.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush_in                 synchronous flush: drops this cycle's grants
//   req_valid_in[RS_SIZE]    entry i valid with operands ready
//   req_fu_in                FU id of entry i at [i*FU_SIZE +: FU_SIZE]
//   fu_ready_in[FU_ARRAY]    FU f can accept an op
//   grant{1,2}_valid/idx/fu  registered issue slots
//   grant_mask_out           one-hot OR of granted entries
//   stall_out                requests were present but nothing was granted
//   issued_count             wrapping count of issued ops
module issue_select_scheduler #(
  parameter int RS_SIZE  = 16,
  parameter int IDX_W    = 4,
  parameter int FU_SIZE  = 2,
  parameter int FU_ARRAY = 3,
  parameter int ALU_LAT  = 1,
  parameter int MEM_LAT  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_in,
  input  logic [RS_SIZE-1:0]          req_valid_in,
  input  logic [RS_SIZE*FU_SIZE-1:0]  req_fu_in,
  input  logic [FU_ARRAY-1:0]         fu_ready_in,
  output logic                        grant1_valid,
  output logic                        grant2_valid,
  output logic [IDX_W-1:0]            grant1_idx,
  output logic [IDX_W-1:0]            grant2_idx,
  output logic [FU_SIZE-1:0]          grant1_fu,
  output logic [FU_SIZE-1:0]          grant2_fu,
  output logic [RS_SIZE-1:0]          grant_mask_out,
  output logic                        stall_out,
  output logic [15:0]                 issued_count
);

  localparam int MAX_LAT  = (MEM_LAT > ALU_LAT) ? MEM_LAT : ALU_LAT;
  localparam int CNT_W    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int FU_SPACE = 1 << FU_SIZE;

  logic [IDX_W-1:0]   rr_ptr;
  logic [RS_SIZE-1:0] pend_mask;
  logic [CNT_W-1:0]   busy_cnt [FU_ARRAY];

  // Sized to the full FU id space so out-of-range ids read as unavailable.
  logic [FU_SPACE-1:0] fu_avail;
  logic [RS_SIZE-1:0]  eligible;

  logic               s1_vld_p0, s2_vld_p0;
  logic [IDX_W-1:0]   s1_idx_p0, s2_idx_p0;
  logic [FU_SIZE-1:0] s1_fu_p0, s2_fu_p0;
  logic [RS_SIZE-1:0] mask_p0;
  logic [IDX_W-1:0]   scan_idx;
  logic [FU_SIZE-1:0] scan_fu;

  function automatic logic [CNT_W-1:0] fu_lat_m1(input int f);
    return (f < 2) ? CNT_W'(ALU_LAT - 1) : CNT_W'(MEM_LAT - 1);
  endfunction

  // ---- stage p0: availability, eligibility and round-robin selection ----
  always_comb begin
    fu_avail = '0;
    for (int f = 0; f < FU_ARRAY; f++)
      fu_avail[f] = fu_ready_in[f] & (busy_cnt[f] == '0);
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < RS_SIZE; i++)
      eligible[i] = req_valid_in[i] & ~pend_mask[i] &
                    fu_avail[req_fu_in[i*FU_SIZE +: FU_SIZE]];
  end

  always_comb begin
    s1_vld_p0 = 1'b0;
    s2_vld_p0 = 1'b0;
    s1_idx_p0 = '0;
    s2_idx_p0 = '0;
    s1_fu_p0  = '0;
    s2_fu_p0  = '0;
    scan_idx  = '0;
    scan_fu   = '0;
    for (int k = 0; k < RS_SIZE; k++) begin
      scan_idx = rr_ptr + IDX_W'(k);
      scan_fu  = req_fu_in[scan_idx*FU_SIZE +: FU_SIZE];
      if (eligible[scan_idx]) begin
        if (!s1_vld_p0) begin
          s1_vld_p0 = 1'b1;
          s1_idx_p0 = scan_idx;
          s1_fu_p0  = scan_fu;
        end else if (!s2_vld_p0 && (scan_fu != s1_fu_p0)) begin
          s2_vld_p0 = 1'b1;
          s2_idx_p0 = scan_idx;
          s2_fu_p0  = scan_fu;
        end
      end
    end
  end

  always_comb begin
    mask_p0 = '0;
    if (s1_vld_p0) mask_p0 = mask_p0 | (RS_SIZE'(1) << s1_idx_p0);
    if (s2_vld_p0) mask_p0 = mask_p0 | (RS_SIZE'(1) << s2_idx_p0);
  end

  // ---- stage p1: registered grants, pointer, occupancy and status ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant1_valid   <= 1'b0;
      grant2_valid   <= 1'b0;
      grant1_idx     <= '0;
      grant2_idx     <= '0;
      grant1_fu      <= '0;
      grant2_fu      <= '0;
      grant_mask_out <= '0;
      stall_out      <= 1'b0;
      issued_count   <= '0;
      rr_ptr         <= '0;
      pend_mask      <= '0;
      for (int f = 0; f < FU_ARRAY; f++) busy_cnt[f] <= '0;
    end else begin
      // In-flight FU ops are not cancelled by a flush, so counters keep running.
      for (int f = 0; f < FU_ARRAY; f++) begin
        if (!flush_in &&
            ((s1_vld_p0 && s1_fu_p0 == FU_SIZE'(f)) ||
             (s2_vld_p0 && s2_fu_p0 == FU_SIZE'(f))))
          busy_cnt[f] <= fu_lat_m1(f);
        else if (busy_cnt[f] != '0)
          busy_cnt[f] <= busy_cnt[f] - CNT_W'(1);
      end

      if (flush_in) begin
        grant1_valid   <= 1'b0;
        grant2_valid   <= 1'b0;
        grant1_idx     <= '0;
        grant2_idx     <= '0;
        grant1_fu      <= '0;
        grant2_fu      <= '0;
        grant_mask_out <= '0;
        pend_mask      <= '0;
        stall_out      <= 1'b0;
        rr_ptr         <= '0;
      end else begin
        grant1_valid   <= s1_vld_p0;
        grant2_valid   <= s2_vld_p0;
        grant1_idx     <= s1_idx_p0;
        grant2_idx     <= s2_idx_p0;
        grant1_fu      <= s1_fu_p0;
        grant2_fu      <= s2_fu_p0;
        grant_mask_out <= mask_p0;
        pend_mask      <= mask_p0;
        stall_out      <= (|req_valid_in) & ~(s1_vld_p0 | s2_vld_p0);
        issued_count   <= issued_count + 16'(s1_vld_p0) + 16'(s2_vld_p0);
        if (s2_vld_p0)
          rr_ptr <= s2_idx_p0 + IDX_W'(1);
        else if (s1_vld_p0)
          rr_ptr <= s1_idx_p0 + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_select_scheduler.sv
// Testbench for issue_select_scheduler. The bench plays the issue queue:
// it presents requests, pushes the expected registered result for each cycle
// into a scoreboard queue, and compares after the following clock edge.
module tb_issue_select_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_in;
  logic [15:0] req_valid_in;
  logic [31:0] req_fu_in;
  logic [2:0]  fu_ready_in;
  logic        grant1_valid, grant2_valid;
  logic [3:0]  grant1_idx, grant2_idx;
  logic [1:0]  grant1_fu, grant2_fu;
  logic [15:0] grant_mask_out;
  logic        stall_out;
  logic [15:0] issued_count;

  issue_select_scheduler dut (
    .clk(clk), .rst(rst), .flush_in(flush_in),
    .req_valid_in(req_valid_in), .req_fu_in(req_fu_in), .fu_ready_in(fu_ready_in),
    .grant1_valid(grant1_valid), .grant2_valid(grant2_valid),
    .grant1_idx(grant1_idx), .grant2_idx(grant2_idx),
    .grant1_fu(grant1_fu), .grant2_fu(grant2_fu),
    .grant_mask_out(grant_mask_out), .stall_out(stall_out),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        g1v;
    logic [3:0]  g1i;
    logic [1:0]  g1f;
    logic        g2v;
    logic [3:0]  g2i;
    logic [1:0]  g2f;
    logic [15:0] mask;
    logic        stall;
    logic [15:0] cnt;
  } res_t;

  res_t        exp_q[$];
  int          n_cmp;
  int          n_fail;
  logic [15:0] exp_issued;

  // Index/FU of an invalid slot carry no meaning, so they are zeroed.
  function automatic res_t obs();
    res_t r;
    r.g1v   = grant1_valid;
    r.g1i   = grant1_valid ? grant1_idx : 4'd0;
    r.g1f   = grant1_valid ? grant1_fu  : 2'd0;
    r.g2v   = grant2_valid;
    r.g2i   = grant2_valid ? grant2_idx : 4'd0;
    r.g2f   = grant2_valid ? grant2_fu  : 2'd0;
    r.mask  = grant_mask_out;
    r.stall = stall_out;
    r.cnt   = issued_count;
    return r;
  endfunction

  task automatic expect_grant(input logic g1v, input int g1i, input int g1f,
                              input logic g2v, input int g2i, input int g2f,
                              input logic stall);
    res_t e;
    e.g1v   = g1v;
    e.g1i   = g1v ? g1i[3:0] : 4'd0;
    e.g1f   = g1v ? g1f[1:0] : 2'd0;
    e.g2v   = g2v;
    e.g2i   = g2v ? g2i[3:0] : 4'd0;
    e.g2f   = g2v ? g2f[1:0] : 2'd0;
    e.mask  = '0;
    if (g1v) e.mask[g1i] = 1'b1;
    if (g2v) e.mask[g2i] = 1'b1;
    e.stall = stall;
    exp_issued = exp_issued + 16'(g1v) + 16'(g2v);
    e.cnt   = exp_issued;
    exp_q.push_back(e);
  endtask

  task automatic req(input int i, input int fu);
    req_valid_in[i]      = 1'b1;
    req_fu_in[i*2 +: 2]  = fu[1:0];
  endtask

  task automatic unreq(input int i);
    req_valid_in[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_t e, o, zero;
    zero = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    o = obs(); n_cmp++;
    if (o !== zero) begin n_fail++; $display("FAIL reset_state: got %h required %h", o, zero); end
    n_cmp++;
    if (dut.rr_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_rr: got %0d required 0", dut.rr_ptr); end
    // Grant in flight, then reset asserted between edges.
    req(2, 0);
    expect_grant(1, 2, 0, 0, 0, 0, 0);
    tick();
    e = exp_q.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL pre_reset_grant: got %h required %h", o, e); end
    #2 rst = 1'b1;
    #1;
    o = obs(); n_cmp++;
    if (o !== zero) begin n_fail++; $display("FAIL async_reset: got %h required %h", o, zero); end
    n_cmp++;
    if (dut.rr_ptr !== 4'd0) begin n_fail++; $display("FAIL async_reset_rr: got %0d required 0", dut.rr_ptr); end
    unreq(2);
    #2 rst = 1'b0;
    exp_issued = '0;
    expect_grant(0, 0, 0, 0, 0, 0, 0);
    tick();
    e = exp_q.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL idle: got %h required %h", o, e); end
  endtask

  task automatic test_dual();
    for (int c = 0; c < 3; c++) begin
      res_t e, o;
      case (c)
        0:       begin req(2, 0); req(5, 2); expect_grant(1, 2, 0, 1, 5, 2, 0); end
        default: begin req_valid_in = '0; expect_grant(0, 0, 0, 0, 0, 0, 0); end
      endcase
      tick();
      e = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL dual[%0d]: got %h required %h", c, o, e); end
      if (c == 0) begin
        n_cmp++;
        if (dut.rr_ptr !== 4'd6) begin n_fail++; $display("FAIL dual_rr: got %0d required 6", dut.rr_ptr); end
      end
    end
  endtask

  task automatic test_conflict();
    for (int c = 0; c < 4; c++) begin
      res_t e, o;
      case (c)
        0: begin req(1, 1); req(3, 1); req(4, 1); expect_grant(1, 1, 1, 0, 0, 0, 0); end
        1: expect_grant(1, 3, 1, 0, 0, 0, 0);
        2: begin unreq(1); expect_grant(1, 4, 1, 0, 0, 0, 0); end
        default: begin unreq(3); unreq(4); expect_grant(0, 0, 0, 0, 0, 0, 0); end
      endcase
      tick();
      e = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL conflict[%0d]: got %h required %h", c, o, e); end
    end
    n_cmp++;
    if (dut.rr_ptr !== 4'd5) begin n_fail++; $display("FAIL conflict_rr: got %0d required 5", dut.rr_ptr); end
  endtask

  task automatic test_mem_occupancy();
    for (int c = 0; c < 7; c++) begin
      res_t e, o;
      case (c)
        0: begin req(0, 2); req(1, 2); expect_grant(1, 0, 2, 0, 0, 0, 0); end
        1: expect_grant(0, 0, 0, 0, 0, 0, 1);
        2: begin unreq(0); expect_grant(0, 0, 0, 0, 0, 0, 1); end
        3: expect_grant(1, 1, 2, 0, 0, 0, 0);
        4: begin unreq(1); expect_grant(0, 0, 0, 0, 0, 0, 0); end
        default: expect_grant(0, 0, 0, 0, 0, 0, 0);
      endcase
      tick();
      e = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL mem[%0d]: got %h required %h", c, o, e); end
      if (c == 3) begin
        n_cmp++;
        if (dut.rr_ptr !== 4'd2) begin n_fail++; $display("FAIL mem_rr: got %0d required 2", dut.rr_ptr); end
      end
    end
  endtask

  // fu_ready drop while MEM is busy, plus an out-of-range FU id (3).
  task automatic test_fu_ready();
    for (int c = 0; c < 8; c++) begin
      res_t e, o;
      case (c)
        0: begin req(7, 2); req(9, 3); expect_grant(1, 7, 2, 0, 0, 0, 0); end
        1: begin fu_ready_in = 3'b011; expect_grant(0, 0, 0, 0, 0, 0, 1); end
        2: begin unreq(7); req(10, 2); expect_grant(0, 0, 0, 0, 0, 0, 1); end
        3: expect_grant(0, 0, 0, 0, 0, 0, 1);
        4: begin fu_ready_in = 3'b111; expect_grant(1, 10, 2, 0, 0, 0, 0); end
        5: begin unreq(9); unreq(10); expect_grant(0, 0, 0, 0, 0, 0, 0); end
        default: expect_grant(0, 0, 0, 0, 0, 0, 0);
      endcase
      tick();
      e = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL fu_ready[%0d]: got %h required %h", c, o, e); end
      if (c == 4) begin
        n_cmp++;
        if (dut.rr_ptr !== 4'd11) begin n_fail++; $display("FAIL fu_ready_rr: got %0d required 11", dut.rr_ptr); end
      end
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 3; c++) begin
      res_t e, o;
      case (c)
        0: begin req(14, 0); expect_grant(1, 14, 0, 0, 0, 0, 0); end
        1: begin unreq(14); req(15, 0); req(0, 1); expect_grant(1, 15, 0, 1, 0, 1, 0); end
        default: begin req_valid_in = '0; expect_grant(0, 0, 0, 0, 0, 0, 0); end
      endcase
      tick();
      e = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL wrap[%0d]: got %h required %h", c, o, e); end
      if (c == 0) begin
        n_cmp++;
        if (dut.rr_ptr !== 4'd15) begin n_fail++; $display("FAIL wrap_rr0: got %0d required 15", dut.rr_ptr); end
      end
      if (c == 1) begin
        n_cmp++;
        if (dut.rr_ptr !== 4'd1) begin n_fail++; $display("FAIL wrap_rr1: got %0d required 1", dut.rr_ptr); end
      end
    end
  endtask

  // MEM is loaded (busy 2) just before the flush; entry 6 on MEM must only
  // become grantable two edges later, showing the counter kept running.
  task automatic test_flush();
    for (int c = 0; c < 7; c++) begin
      res_t e, o;
      flush_in = 1'b0;
      case (c)
        0: begin req(3, 2); expect_grant(1, 3, 2, 0, 0, 0, 0); end
        1: begin
          unreq(3); req(4, 0); req(6, 2); req(8, 0); req(9, 1);
          flush_in = 1'b1;
          expect_grant(0, 0, 0, 0, 0, 0, 0);
        end
        2: expect_grant(1, 4, 0, 1, 9, 1, 0);
        3: begin unreq(4); unreq(9); expect_grant(1, 6, 2, 1, 8, 0, 0); end
        4: begin req_valid_in = '0; expect_grant(0, 0, 0, 0, 0, 0, 0); end
        default: expect_grant(0, 0, 0, 0, 0, 0, 0);
      endcase
      tick();
      e = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL flush[%0d]: got %h required %h", c, o, e); end
      if (c == 1) begin
        n_cmp++;
        if (dut.rr_ptr !== 4'd0) begin n_fail++; $display("FAIL flush_rr: got %0d required 0", dut.rr_ptr); end
      end
    end
    flush_in = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    exp_issued   = '0;
    rst          = 1'b1;
    flush_in     = 1'b0;
    req_valid_in = '0;
    req_fu_in    = '0;
    fu_ready_in  = 3'b111;
    test_reset();
    test_dual();
    test_conflict();
    test_mem_occupancy();
    test_fu_ready();
    test_wrap();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/issue_select_scheduler.md
# issue_select_scheduler

Issue-select controller for the unified issue queue. Each cycle it picks up to two ready queue entries and binds each to a distinct, available functional unit: ALU0, ALU1 or the memory unit. Selection is round-robin across entries, and multi-cycle FU occupancy is tracked internally. It sits between the issue-queue entry array (requests) and the FU issue ports (registered grants).

## Interface
Parameters:
- RS_SIZE, 16, number of issue-queue entries (power of two)
- IDX_W, 4, log2(RS_SIZE)
- FU_SIZE, 2, FU id width
- FU_ARRAY, 3, number of FUs (0=ALU0, 1=ALU1, 2=MEM)
- ALU_LAT, 1, ALU occupancy in cycles (>=1)
- MEM_LAT, 3, MEM occupancy in cycles (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush_in  in  1  synchronous flush
- req_valid_in  in  RS_SIZE  entry i valid and both operands ready
- req_fu_in  in  RS_SIZE*FU_SIZE  FU id of entry i, bits [i*FU_SIZE +: FU_SIZE]
- fu_ready_in  in  FU_ARRAY  FU f can accept an op
- grant1_valid, grant2_valid  out  1  issue slot valid
- grant1_idx, grant2_idx  out  IDX_W  granted entry index
- grant1_fu, grant2_fu  out  FU_SIZE  FU bound to the slot
- grant_mask_out  out  RS_SIZE  one-hot OR of both grants; the queue clears these entries
- stall_out  out  1  requests present, none granted
- issued_count  out  16  total ops issued, wrapping

## Operation
FU availability:
- fu_avail[f] = fu_ready_in[f] & (busy_cnt[f]==0).
- A req_fu value >= FU_ARRAY is never eligible.

Entry eligibility:
- eligible[i] = req_valid_in[i] & ~pend_mask[i] & fu_avail[req_fu[i]].
- pend_mask is the previous cycle's grant_mask_out. It blocks a re-grant during the cycle the queue clears the entry.

Selection:
- Scan indices rr_ptr, rr_ptr+1, …, wrapping mod RS_SIZE.
- Slot 1 takes the first eligible entry.
- Slot 2 takes the next eligible entry, in the same scan order, whose FU differs from slot 1's FU.
- Two entries never share an FU in one cycle.

Round-robin pointer:
- rr_ptr <= (last granted idx + 1) mod RS_SIZE, using slot 2 if valid, else slot 1.
- rr_ptr is unchanged when nothing is granted.

Busy counters:
- On a grant to FU f: busy_cnt[f] <= LAT(f)-1, where LAT is ALU_LAT for f<2 and MEM_LAT for f=2.
- Otherwise busy_cnt[f] decrements if nonzero.
- With ALU_LAT=1 an ALU can be granted every cycle. With MEM_LAT=3 the MEM unit is blocked for the 2 cycles after a grant.

Counters and status:
- issued_count adds grant1_valid + grant2_valid per registered cycle, and wraps at 2^16.
- stall_out <= |req_valid_in & ~(slot1 | slot2 granted).

Flush (flush_in=1 at an edge):
- Clears grant*_valid, grant_mask_out, pend_mask and stall_out.
- Sets rr_ptr to 0.
- No grant is made that cycle.
- busy_cnt continues counting down, because in-flight FU ops are not cancelled.
- issued_count is held.

Reset (rst=1, asynchronous, any time including mid-operation):
- Forces to 0: all outputs, rr_ptr, pend_mask and busy_cnt.
- Grants resume on the first edge after rst deasserts.

## Timing
- Selection is combinational from the current inputs and state.
- All outputs are registered: a request seen at edge N produces grant outputs valid after edge N.
- grant outputs are held for exactly 1 cycle unless re-granted.
- The queue must clear granted entries at the edge following the grant; pend_mask covers that single cycle.
- Busy counters load and decrement at the same edge the grant registers.

Boundary conditions:
- All requests on one FU: at most 1 grant per cycle.
- No requests: grants invalid, stall_out=0, rr_ptr held.
- Wrap-around: rr_ptr=15 with eligible entries 15 and 0 on different FUs gives slot1=15, slot2=0, rr_ptr->1.
- fu_ready_in dropping while busy_cnt is nonzero: the FU stays unavailable until both conditions are clear.

## Test plan
- Reset then idle: rst pulse mid-grant -> all outputs 0 immediately. Then req_valid=0 -> no grants, stall_out=0, issued_count=0.
- Dual issue: entry 2 on FU0, entry 5 on FU2, fu_ready=3'b111 -> grant1 idx=2 fu=0, grant2 idx=5 fu=2, grant_mask=0x0024, rr_ptr=6, issued_count=2.
- FU conflict: entries 1, 3, 4 all on FU1 -> cycle 1 grants idx 1 only. Entry 1 is masked the next cycle (pend_mask) and the queue clears it, so the following cycle grants idx 3, then idx 4 (rr order).
- MEM occupancy: entries 0 and 1 on FU2, MEM_LAT=3 -> idx 0 granted at cycle 1, idx 1 granted at cycle 4. stall_out=1 at cycles 2–3.
- Wrap: rr_ptr=15, entries 15 (FU0) and 0 (FU1) -> slot1=15, slot2=0, rr_ptr=1.
- Flush: flush_in with 4 valid requests -> no grants that cycle and rr_ptr=0. A MEM busy_cnt of 2 still decrements to 0 over 2 cycles.
